// File: rtl/bus_bridge.sv
// Decodes core data accesses to data RAM or on-board I/O (LED, 7-seg, switches, timer); reads are combinational.
// Timer present only when BRIDGE_TIMER_EN is defined; otherwise TCNT/TDIV read 0 and ignore writes.
module bus_bridge #(
    parameter int DRAM_AW  = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    localparam logic [9:0] OFS_DIG  = 10'h000;
    localparam logic [9:0] OFS_TCNT = 10'h008;
    localparam logic [9:0] OFS_TDIV = 10'h009;
    localparam logic [9:0] OFS_LED  = 10'h018;
    localparam logic [9:0] OFS_SW   = 10'h01C;
    localparam logic [9:0] OFS_BTN  = 10'h01E;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic       io_sel;
    logic       io_wen;
    logic [9:0] word;
    logic       unused_addr_bits;

    // I/O space is the top 4 KiB, so only the low word offset needs decoding.
    assign io_sel           = (Bus_addr >= 32'hFFFF_F000);
    assign io_wen           = Bus_wen & io_sel;
    assign word             = Bus_addr[11:2];
    assign unused_addr_bits = ^Bus_addr[1:0];

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_wen   = Bus_wen & ~io_sel;
    assign dram_wdata = Bus_wdata;

    logic [23:0]    led_q, led_d;
    logic [31:0]    dig_q, dig_d;
    logic [SCW-1:0] scan_q, scan_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     dig_en_q, dig_en_d;
    logic [7:0]     seg_q, seg_d;
    logic [23:0]    sw_meta_q, sw_sync_q;
    logic [4:0]     btn_meta_q, btn_sync_q;
    logic [31:0]    tcnt_rd, tdiv_rd;

    always_comb begin
        led_d    = led_q;
        dig_d    = dig_q;
        scan_d   = scan_q + 1'b1;
        idx_d    = idx_q;
        dig_en_d = ~(8'b1 << idx_q);
        seg_d    = hex7(dig_q[{idx_q, 2'b00} +: 4]);
        if (io_wen && word == OFS_LED) led_d = Bus_wdata[23:0];
        if (io_wen && word == OFS_DIG) dig_d = Bus_wdata;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            led_q      <= '0;
            dig_q      <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            dig_en_q   <= 8'hFF;
            seg_q      <= 8'hFF;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            led_q      <= led_d;
            dig_q      <= dig_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            dig_en_q   <= dig_en_d;
            seg_q      <= seg_d;
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef BRIDGE_TIMER_EN
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tdiv_q, tdiv_d;
    logic [31:0] presc_q, presc_d;
    logic        tick;

    // A TCNT write overrides a coincident tick; any timer write restarts the prescale period.
    always_comb begin
        tick    = (tdiv_q != 32'd0) && (presc_q == tdiv_q - 32'd1);
        tcnt_d  = tick ? tcnt_q + 32'd1 : tcnt_q;
        tdiv_d  = tdiv_q;
        presc_d = presc_q;
        if (tdiv_q != 32'd0) presc_d = tick ? 32'd0 : presc_q + 32'd1;
        if (io_wen && word == OFS_TCNT) begin
            tcnt_d  = Bus_wdata;
            presc_d = 32'd0;
        end
        if (io_wen && word == OFS_TDIV) begin
            tdiv_d  = Bus_wdata;
            presc_d = 32'd0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tcnt_q  <= '0;
            tdiv_q  <= '0;
            presc_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            tdiv_q  <= tdiv_d;
            presc_q <= presc_d;
        end
    end

    assign tcnt_rd = tcnt_q;
    assign tdiv_rd = tdiv_q;
`else
    assign tcnt_rd = 32'd0;
    assign tdiv_rd = 32'd0;
`endif

    always_comb begin
        Bus_rdata = 32'd0;
        if (!io_sel) begin
            Bus_rdata = dram_rdata;
        end else begin
            case (word)
                OFS_DIG:  Bus_rdata = dig_q;
                OFS_TCNT: Bus_rdata = tcnt_rd;
                OFS_TDIV: Bus_rdata = tdiv_rd;
                OFS_LED:  Bus_rdata = {8'd0, led_q};
                OFS_SW:   Bus_rdata = {8'd0, sw_sync_q};
                OFS_BTN:  Bus_rdata = {27'd0, btn_sync_q};
                default:  Bus_rdata = 32'd0;
            endcase
        end
    end

    assign led    = led_q;
    assign dig_en = dig_en_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Directed bench for bus_bridge with SCAN_DIV=4; timer checks follow BRIDGE_TIMER_EN.
module tb_bus_bridge;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_vec = 0;
    int n_err = 0;

    bus_bridge #(.DRAM_AW(14), .SCAN_DIV(4)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .seg        (seg)
    );

    // Behavioural data RAM with combinational read.
    logic [31:0] mem [0:(1<<14)-1];
    always @(posedge cpu_clk) if (dram_wen) mem[dram_addr] <= dram_wdata;
    assign dram_rdata = mem[dram_addr];

    initial cpu_clk = 1'b0;
    always #50 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        Bus_addr  = a;
        Bus_wdata = d;
        Bus_wen   = 1'b1;
        @(posedge cpu_clk);
        #1;
        Bus_wen   = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Bus_addr = a;
        #1;
        check(tag, Bus_rdata, exp);
    endtask

    logic [7:0] seg_exp [0:7];
    int d;

    initial begin
        // DIG = 8765_43A0 -> digits 0..7 show 0,A,3,4,5,6,7,8
        seg_exp[0] = 8'hC0; seg_exp[1] = 8'h88; seg_exp[2] = 8'hB0; seg_exp[3] = 8'h99;
        seg_exp[4] = 8'h92; seg_exp[5] = 8'h82; seg_exp[6] = 8'hF8; seg_exp[7] = 8'h80;

        cpu_rst   = 1'b1;
        Bus_addr  = 32'd0;
        Bus_wen   = 1'b0;
        Bus_wdata = 32'd0;
        sw        = 24'd0;
        btn       = 5'd0;
        tick_n(3);
        check("rst_led", {8'd0, led}, 32'd0);
        check("rst_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
        bus_rd("rst_led_rd", 32'hFFFF_F060, 32'd0);

        cpu_rst = 1'b0;
        tick_n(1);
        check("first_dig_en", {24'd0, dig_en}, 32'h0000_00FE);
        check("first_seg", {24'd0, seg}, 32'h0000_00C0);

        // Display scan: after edge k (k>=1 from reset release) digit (k-1)/4 mod 8 is lit.
        bus_wr(32'hFFFF_F000, 32'h8765_43A0);
        for (int k = 2; k <= 36; k++) begin
            d = ((k - 1) / 4) % 8;
            check($sformatf("scan_en_%0d", k), {24'd0, dig_en}, {24'd0, ~(8'b1 << d)});
            check($sformatf("scan_seg_%0d", k), {24'd0, seg}, {24'd0, seg_exp[d]});
            tick_n(1);
        end
        bus_rd("dig_rd", 32'hFFFF_F000, 32'h8765_43A0);

        // RAM path
        Bus_addr  = 32'h0000_0100;
        Bus_wdata = 32'h1234_5678;
        Bus_wen   = 1'b1;
        #1;
        check("ram_wen", {31'd0, dram_wen}, 32'd1);
        check("ram_addr", {18'd0, dram_addr}, 32'h0000_0040);
        check("ram_wdata", dram_wdata, 32'h1234_5678);
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
        bus_rd("ram_rd", 32'h0000_0100, 32'h1234_5678);
        Bus_addr = 32'hFFFF_EFFC;
        Bus_wen  = 1'b1;
        #1;
        check("ram_top_wen", {31'd0, dram_wen}, 32'd1);
        check("ram_top_addr", {18'd0, dram_addr}, 32'h0000_3BFF);
        Bus_addr = 32'hFFFF_F000;
        #1;
        check("io_base_wen", {31'd0, dram_wen}, 32'd0);
        Bus_wen = 1'b0;

        // LED
        Bus_addr  = 32'hFFFF_F060;
        Bus_wdata = 32'hFFAB_CDEF;
        Bus_wen   = 1'b1;
        #1;
        check("led_dram_wen", {31'd0, dram_wen}, 32'd0);
        check("led_pre", {8'd0, led}, 32'd0);
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
        check("led_out", {8'd0, led}, 32'h00AB_CDEF);
        bus_rd("led_rd", 32'hFFFF_F060, 32'h00AB_CDEF);

        // Switch / button synchronisers
        sw  = 24'h00_5A5A;
        btn = 5'h15;
        tick_n(1);
        bus_rd("sw_1edge", 32'hFFFF_F070, 32'd0);
        bus_rd("btn_1edge", 32'hFFFF_F078, 32'd0);
        tick_n(1);
        bus_rd("sw_2edge", 32'hFFFF_F070, 32'h0000_5A5A);
        bus_rd("btn_2edge", 32'hFFFF_F078, 32'h0000_0015);
        bus_wr(32'hFFFF_F070, 32'hFFFF_FFFF);
        bus_rd("sw_ro", 32'hFFFF_F070, 32'h0000_5A5A);
        bus_wr(32'hFFFF_F100, 32'hDEAD_BEEF);
        bus_rd("unmapped", 32'hFFFF_F100, 32'd0);

`ifdef BRIDGE_TIMER_EN
        bus_wr(32'hFFFF_F024, 32'd3);
        bus_rd("tdiv_rd", 32'hFFFF_F024, 32'd3);
        for (int j = 0; j <= 6; j++) begin
            bus_rd($sformatf("tcnt_run_%0d", j), 32'hFFFF_F020, 32'(j / 3));
            tick_n(1);
        end
        bus_wr(32'hFFFF_F020, 32'hFFFF_FFFF);
        tick_n(2);
        bus_rd("tcnt_prewrap", 32'hFFFF_F020, 32'hFFFF_FFFF);
        tick_n(1);
        bus_rd("tcnt_wrap", 32'hFFFF_F020, 32'd0);
        // Next tick falls on the third edge from here; land a TCNT write on it.
        tick_n(2);
        bus_wr(32'hFFFF_F020, 32'd5);
        bus_rd("tcnt_collide", 32'hFFFF_F020, 32'd5);
        tick_n(2);
        bus_rd("tcnt_collide_hold", 32'hFFFF_F020, 32'd5);
        tick_n(1);
        bus_rd("tcnt_after_collide", 32'hFFFF_F020, 32'd6);
        bus_wr(32'hFFFF_F024, 32'd0);
        tick_n(5);
        bus_rd("tcnt_frozen", 32'hFFFF_F020, 32'd6);
        bus_wr(32'hFFFF_F024, 32'd2);
        tick_n(2);
        bus_rd("tcnt_resume", 32'hFFFF_F020, 32'd7);
`else
        bus_wr(32'hFFFF_F024, 32'd3);
        bus_wr(32'hFFFF_F020, 32'd5);
        tick_n(4);
        bus_rd("tcnt_absent", 32'hFFFF_F020, 32'd0);
        bus_rd("tdiv_absent", 32'hFFFF_F024, 32'd0);
`endif

        // Reset mid-run with a coincident LED write
        bus_wr(32'hFFFF_F060, 32'h0000_00FF);
        check("led_ff", {8'd0, led}, 32'h0000_00FF);
        Bus_addr  = 32'hFFFF_F060;
        Bus_wdata = 32'h0012_3456;
        Bus_wen   = 1'b1;
        cpu_rst   = 1'b1;
        @(posedge cpu_clk);
        #1;
        Bus_wen = 1'b0;
        cpu_rst = 1'b0;
        check("mr_led", {8'd0, led}, 32'd0);
        check("mr_dig_en", {24'd0, dig_en}, 32'h0000_00FF);
        check("mr_seg", {24'd0, seg}, 32'h0000_00FF);
        bus_rd("mr_led_rd", 32'hFFFF_F060, 32'd0);
        bus_rd("mr_dig_rd", 32'hFFFF_F000, 32'd0);
        bus_rd("mr_sw_rd", 32'hFFFF_F070, 32'd0);
        bus_rd("mr_tcnt_rd", 32'hFFFF_F020, 32'd0);
        bus_rd("mr_tdiv_rd", 32'hFFFF_F024, 32'd0);
        tick_n(1);
        check("mr_first_en", {24'd0, dig_en}, 32'h0000_00FE);
        check("mr_first_seg", {24'd0, seg}, 32'h0000_00C0);
        bus_rd("mr_tcnt_still", 32'hFFFF_F020, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
